uart_rx_param: RTL

UART_RX_PARAM -- requirements
Module: uart_rx_param

---
 rtl/uart_rx_param.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/uart_rx_param.sv
// Purpose: parameterised UART receiver with synchroniser, frame/parity checks and a one-word output register.
// Latency: outputs update 1 clk after the final stop sample; optional parity via UART_RX_PARITY_EN.
// Backpressure: rx_valid/rx_ready; a frame completing while a word is still held is dropped with an overrun pulse.
module uart_rx_param #(
    parameter int DATA_W      = 8,
    parameter int BAUD_W      = 20,
    parameter int STOP_BITS   = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_en,
    input  logic [BAUD_W-1:0] baud,
`ifdef UART_RX_PARITY_EN
    input  logic              parity_odd,
`endif
    input  logic              rx_in,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              frame_err,
    output logic              parity_err,
    output logic              overrun,
    output logic              busy
);
    localparam int CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        WAIT_HIGH = 3'd5
    } state_t;

    state_t              state, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                rx_s, rx_s_d, fall;
    logic [BAUD_W-1:0]   baud_lat, baud_cnt, tgt;
    logic [CNT_W-1:0]    bit_cnt;
    logic [DATA_W-1:0]   shreg;
    logic                ferr_acc, frame_bad, run, tick, complete;

    assign rx_s = sync_q[SYNC_STAGES-1];
    assign fall = rx_s_d & ~rx_s;
    assign busy = (state != IDLE);
    assign run  = (state == START) || (state == DATA) || (state == PARITY) || (state == STOP);
    // START waits half a bit to land mid-bit; every later sample is a full bit apart
    assign tgt  = (state == START) ? ((baud_lat >> 1) - BAUD_W'(1)) : (baud_lat - BAUD_W'(1));
    assign tick = run && (baud_cnt == tgt);
    assign frame_bad = ferr_acc | ~rx_s;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    always_comb begin
        state_d  = state;
        complete = 1'b0;
        if (state != IDLE && !rx_en) begin
            state_d = IDLE;
        end else begin
            case (state)
                IDLE:      if (rx_en && fall) state_d = START;
                START:     if (tick) state_d = rx_s ? IDLE : DATA;
                DATA: begin
                    if (tick && bit_cnt == CNT_W'(DATA_W - 1)) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
                PARITY:    if (tick) state_d = STOP;
                STOP: begin
                    if (tick && bit_cnt == CNT_W'(STOP_BITS - 1)) begin
                        complete = 1'b1;
                        state_d  = frame_bad ? WAIT_HIGH : IDLE;
                    end
                end
                WAIT_HIGH: if (rx_s) state_d = IDLE;
                default:   state_d = IDLE;
            endcase
        end
    end

`ifdef UART_RX_PARITY_EN
    logic par_bit, perr_q;
    assign parity_err = perr_q;
`else
    assign parity_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q    <= '1;
            rx_s_d    <= 1'b1;
            baud_lat  <= '0;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            ferr_acc  <= 1'b0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit   <= 1'b0;
            perr_q    <= 1'b0;
`endif
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], rx_in};
            rx_s_d  <= rx_s;
            overrun <= 1'b0;
            if (state == IDLE && state_d == START) baud_lat <= baud;

            if (state_d != state || tick) baud_cnt <= '0;
            else if (run)                 baud_cnt <= baud_cnt + BAUD_W'(1);

            if (state_d != state) bit_cnt <= '0;
            else if (tick)        bit_cnt <= bit_cnt + CNT_W'(1);

            if (state == DATA && tick) shreg <= {rx_s, shreg[DATA_W-1:1]};

            if (state == IDLE)              ferr_acc <= 1'b0;
            else if (state == STOP && tick) ferr_acc <= frame_bad;
`ifdef UART_RX_PARITY_EN
            if (state == PARITY && tick) par_bit <= rx_s;
`endif
            if (complete) begin
                if (!rx_valid || rx_ready) begin
                    rx_data   <= shreg;
                    rx_valid  <= 1'b1;
                    frame_err <= frame_bad;
`ifdef UART_RX_PARITY_EN
                    perr_q    <= ((^shreg) ^ par_bit) != parity_odd;
`endif
                end else begin
                    overrun <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end
endmodule
